// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkg
// Description : Shared helpers and default beat type for AXIS width stages.
// Revision    : 1.0
// ============================================================================
package axis_pkg;

    function automatic int ratio(input int m_words, input int s_words);
        return m_words / s_words;
    endfunction

    // Counter width that never collapses to zero bits for a range of one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_WORD_W  = 8;
    localparam int DEF_M_WORDS = 4;

    typedef struct packed {
        logic [DEF_M_WORDS-1:0][DEF_WORD_W-1:0] data;
        logic [DEF_M_WORDS-1:0]                 keep;
        logic                                   last;
    } out_beat_t;

endpackage
`default_nettype wire

// File: rtl/axis_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : axis_out_reg
// Description : Single-entry output holding register with valid/ready logic.
// Revision    : 1.0
// ============================================================================
module axis_out_reg
    import axis_pkg::*;
#(
    parameter type T_BEAT = axis_pkg::out_beat_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_load,
    input  T_BEAT i_data,
    input  logic  i_ready,
    output logic  o_valid,
    output T_BEAT o_data,
    output logic  o_can_load
);

    logic  r_valid;
    T_BEAT r_data;

    // A load is legal when empty or when the held beat leaves this cycle.
    assign o_can_load = !r_valid || i_ready;
    assign o_valid    = r_valid;
    assign o_data     = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_packer.sv
`default_nettype none
// ============================================================================
// Module      : axis_packer
// Description : AXIS width upsizer packing S_WORDS-word beats into M_WORDS-word
//               beats with per-packet last/keep generation and zero padding.
// Revision    : 1.0
// ============================================================================
module axis_packer
    import axis_pkg::*;
#(
    parameter int WORD_W  = 8,
    parameter int S_WORDS = 1,
    parameter int M_WORDS = 4,
    parameter int N_BEATS = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [S_WORDS-1:0][WORD_W-1:0]   s_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [M_WORDS-1:0][WORD_W-1:0]   m_data,
    output logic [M_WORDS-1:0]               m_keep,
    output logic                             m_last
);

    localparam int R      = ratio(M_WORDS, S_WORDS);
    localparam int SLOT_W = cnt_w(R);
    localparam int BEAT_W = cnt_w(N_BEATS);

    localparam logic [SLOT_W-1:0] c_SLOT_LAST = SLOT_W'(R - 1);
    localparam logic [BEAT_W-1:0] c_BEAT_LAST = BEAT_W'(N_BEATS - 1);

    typedef struct packed {
        logic [M_WORDS-1:0][WORD_W-1:0] data;
        logic [M_WORDS-1:0]             keep;
        logic                           last;
    } beat_t;

    logic [R-1:0][S_WORDS-1:0][WORD_W-1:0] r_acc;
    logic [SLOT_W-1:0]                     r_slot;
    logic [BEAT_W-1:0]                     r_beat;

    logic                                  w_fire;
    logic                                  w_last_beat;
    logic                                  w_complete;
    logic                                  w_can_load;
    logic [R-1:0][S_WORDS-1:0][WORD_W-1:0] w_slots;
    logic [R-1:0][S_WORDS-1:0]             w_keep_slots;
    beat_t                                 w_beat;
    beat_t                                 w_out;

    assign w_last_beat = (r_beat == c_BEAT_LAST);
    assign w_complete  = (r_slot == c_SLOT_LAST) || w_last_beat;
    assign s_ready     = !rst && !(w_complete && !w_can_load);
    assign w_fire      = s_valid && s_ready;

    // Wide beat as it would look if the current input beat completes it;
    // slots past the current one are stale and must read as zero padding.
    always_comb begin
        w_slots      = '0;
        w_keep_slots = '0;
        for (int i = 0; i < R; i++) begin
            if (SLOT_W'(i) < r_slot) begin
                w_slots[i]      = r_acc[i];
                w_keep_slots[i] = '1;
            end else if (SLOT_W'(i) == r_slot) begin
                w_slots[i]      = s_data;
                w_keep_slots[i] = '1;
            end
        end
        w_beat      = '0;
        w_beat.data = w_slots;
        w_beat.keep = w_keep_slots;
        w_beat.last = w_last_beat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_slot <= '0;
            r_beat <= '0;
        end else if (w_fire) begin
            if (w_complete) begin
                r_slot <= '0;
            end else begin
                r_acc[r_slot] <= s_data;
                r_slot        <= r_slot + 1'b1;
            end
            r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
        end
    end

    axis_out_reg #(
        .T_BEAT (beat_t)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_fire && w_complete),
        .i_data     (w_beat),
        .i_ready    (m_ready),
        .o_valid    (m_valid),
        .o_data     (w_out),
        .o_can_load (w_can_load)
    );

    assign m_data = w_out.data;
    assign m_keep = w_out.keep;
    assign m_last = w_out.last;

endmodule
`default_nettype wire

// File: tb/tb_axis_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_packer
// Description : Scoreboard bench for axis_packer (N_BEATS=10 and N_BEATS=2).
// Revision    : 1.0
// ============================================================================
module tb_axis_packer;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_valid, s_ready, m_valid, m_ready, m_last;
    logic [0:0][7:0] s_data;
    logic [3:0][7:0] m_data;
    logic [3:0]      m_keep;
    logic            s2_valid, s2_ready, m2_valid, m2_ready, m2_last;
    logic [0:0][7:0] s2_data;
    logic [3:0][7:0] m2_data;
    logic [3:0]      m2_keep;

    exp_t q[$];
    exp_t q2[$];
    int   n_cmp       = 0;
    int   n_err       = 0;
    int   rdy_pct     = 100;
    int   rdy_hold    = 0;
    int   stall_cnt   = 0;
    int   first_stall = -1;
    int   out_pos     = 0;

    always #5 clk = ~clk;

    axis_packer #(.WORD_W(8), .S_WORDS(1), .M_WORDS(4), .N_BEATS(10)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_keep(m_keep), .m_last(m_last)
    );

    axis_packer #(.WORD_W(8), .S_WORDS(1), .M_WORDS(4), .N_BEATS(2)) dut2 (
        .clk(clk), .rst(rst),
        .s_valid(s2_valid), .s_ready(s2_ready), .s_data(s2_data),
        .m_valid(m2_valid), .m_ready(m2_ready), .m_data(m2_data),
        .m_keep(m2_keep), .m_last(m2_last)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Sink ready: forced low while rdy_hold counts down, else random at rdy_pct.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_hold > 0) begin
                m_ready = 1'b0;
                rdy_hold--;
            end else begin
                m_ready = ($urandom_range(1, 100) <= rdy_pct);
            end
        end
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        exp_t e;
        exp_t prev;
        bit   prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                out_pos    = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("hold_stable", {m_data, m_keep, m_last}, prev);
                if (m_valid && m_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_beat", {m_data, m_keep, m_last}, 64'hx);
                    end else begin
                        e = q.pop_front();
                        check("out_beat", {m_data, m_keep, m_last}, e);
                    end
                    check("last_period", m_last, (out_pos % 3 == 2));
                    out_pos++;
                end
                prev_stall = m_valid && !m_ready;
                prev       = {m_data, m_keep, m_last};
                if (m2_valid && m2_ready) begin
                    if (q2.size() == 0) begin
                        check("unexpected_beat2", {m2_data, m2_keep, m2_last}, 64'hx);
                    end else begin
                        e = q2.pop_front();
                        check("out_beat2", {m2_data, m2_keep, m2_last}, e);
                    end
                end
            end
        end
    end

    task automatic push_const(input logic [31:0] d, input logic [3:0] k, input logic l);
        q.push_back({d, k, l});
    endtask

    task automatic push_model(input logic [7:0] w [10]);
        exp_t e;
        for (int b = 0; b < 3; b++) begin
            e = '0;
            for (int j = 0; j < 4; j++) begin
                if (b * 4 + j < 10) begin
                    e.data[j*8 +: 8] = w[b*4 + j];
                    e.keep[j]        = 1'b1;
                end
            end
            e.last = (b == 2);
            q.push_back(e);
        end
    endtask

    task automatic send_word(input logic [7:0] v, input int gap_pct, input int idx);
        int t;
        while ($urandom_range(1, 100) <= gap_pct) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid   = 1'b1;
        s_data[0] = v;
        t = 0;
        forever begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk); #1;
                s_valid = 1'b0;
                break;
            end
            stall_cnt++;
            if (first_stall < 0) first_stall = idx;
            t++;
            if (t > 500) begin
                check("accept_timeout", t, 0);
                @(posedge clk); #1;
                s_valid = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic send_pkt(input logic [7:0] w [10], input int n, input int gap_pct);
        for (int k = 0; k < n; k++) send_word(w[k], gap_pct, k);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || q2.size() != 0) && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_left", q.size() + q2.size(), 0);
    endtask

    initial begin
        logic [7:0] w [10];
        int         t;
        rst = 1'b1; s_valid = 1'b0; s_data = '0;
        s2_valid = 1'b0; s2_data = '0; m2_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_keep", m_keep, 0);
        check("rst_m_last", m_last, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full-rate packet 0x01..0x0A
        for (int k = 0; k < 10; k++) w[k] = 8'(k + 1);
        push_const(32'h04030201, 4'b1111, 1'b0);
        push_const(32'h08070605, 4'b1111, 1'b0);
        push_const(32'h00000A09, 4'b0011, 1'b1);
        stall_cnt = 0;
        send_pkt(w, 10, 0);
        check("stall_cycles_p1", stall_cnt, 0);

        // Back-to-back packet, must not mix with the previous tail
        for (int k = 0; k < 10; k++) w[k] = 8'(8'h11 + k);
        push_const(32'h14131211, 4'b1111, 1'b0);
        push_const(32'h18171615, 4'b1111, 1'b0);
        push_const(32'h00001A19, 4'b0011, 1'b1);
        send_pkt(w, 10, 0);
        drain();

        // Sink held off while the source streams
        for (int k = 0; k < 10; k++) w[k] = 8'(8'h21 + k);
        push_model(w);
        first_stall = -1;
        rdy_hold    = 8;
        send_pkt(w, 10, 0);
        check("first_stall_word", first_stall, 7);
        drain();

        // Random source gaps and random sink ready
        rdy_pct = 70;
        for (int p = 0; p < 100; p++) begin
            for (int k = 0; k < 10; k++) w[k] = 8'($urandom_range(0, 255));
            push_model(w);
            send_pkt(w, 10, 30);
        end
        drain();
        rdy_pct = 100;

        // Reset after 6 beats: only the first wide beat ever leaves
        for (int k = 0; k < 10; k++) w[k] = 8'(k + 1);
        push_const(32'h04030201, 4'b1111, 1'b0);
        send_pkt(w, 6, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_s_ready", s_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_m_data", m_data, 0);
        @(posedge clk); #1;
        push_const(32'h04030201, 4'b1111, 1'b0);
        push_const(32'h08070605, 4'b1111, 1'b0);
        push_const(32'h00000A09, 4'b0011, 1'b1);
        stall_cnt = 0;
        send_pkt(w, 10, 0);
        check("stall_cycles_after_rst", stall_cnt, 0);
        drain();

        // N_BEATS=2 instance: single short beat
        q2.push_back({32'h00000201, 4'b0011, 1'b1});
        for (int k = 0; k < 2; k++) begin
            s2_valid   = 1'b1;
            s2_data[0] = 8'(k + 1);
            t = 0;
            forever begin
                @(negedge clk);
                if (s2_ready || t > 100) break;
                t++;
                @(posedge clk); #1;
            end
            check("dut2_accept", s2_ready, 1);
            @(posedge clk); #1;
            s2_valid = 1'b0;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
